gpr_writeback: RTL and testbench
================================

Name: gpr_writeback

Overview:
- Writeback initiator for the GPR write port; it is the writer side of the register file.
- Accepts results from two producers: the ALU (rd, data) and the load path (rd, data).
- Queues the results in program order in a small FIFO and drains one entry per cycle into the GPR single write port.
- Provides read-bypass: rs/rt read data reflects writes that are still pending in the queue.

Parameters:
- DEPTH, 4, number of pending-write entries; power of two, ≥2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- mem_valid  in  1  load result offered
- mem_rd  in  5  load destination register
- mem_data  in  32  load data
- mem_ready  out  1  load result accepted this cycle when mem_valid=1
- gpr_we  out  1  GPR write enable
- gpr_waddr  out  5  GPR write address
- gpr_wdata  out  32  GPR write data
- rs_addr, rt_addr  in  5 each  decode-stage read addresses; these also drive the GPR read ports
- rs_gpr, rt_gpr  in  32 each  raw GPR read data
- rs_data, rt_data  out  32 each  bypassed read data
- idle  out  1  queue empty

Behaviour:
- Reset, asynchronous: wr_ptr=0, rd_ptr=0, count=0, entry valid bits cleared.
- During reset: gpr_we=0, alu_ready=0, mem_ready=0, idle=1.
- A reset mid-operation discards all pending writes; none reach the GPR.
- Handshake: a transfer occurs when valid && ready on the same rising edge. Producers hold rd and data stable until accepted.
- Ordering: if both producers transfer in the same cycle, the mem entry is older and is enqueued first, then the alu entry.
- rd=0 results are accepted (ready honoured) but not enqueued; they never write the GPR.
- Ready rules, combinational from count and mem inputs. Same-cycle pop is not credited.
  - mem_ready = (count ≤ DEPTH-1).
  - memtake = mem_valid && mem_ready && mem_rd≠0.
  - alu_ready = memtake ? (count ≤ DEPTH-2) : (count ≤ DEPTH-1).
- Drain:
  - gpr_we = (count≠0); gpr_waddr and gpr_wdata come from the head entry.
  - The GPR commits at the rising edge. The head pops at that same edge; one entry per cycle.
- Latency: a result accepted at edge N is written to the GPR at edge N+1 if the queue was empty; otherwise after all older entries.
- Count update per edge: count_next = count + pushes(0..2) − pop(0/1). Push with pop when full is not allowed, because ready excludes it.
- Pointers wrap modulo DEPTH.
- Bypass, combinational:
  - rs_data = 0 if rs_addr=0.
  - Otherwise the data of the youngest valid queued entry whose rd matches rs_addr.
  - Otherwise rs_gpr.
  - rt_data is identical using rt_addr and rt_gpr.
  - Incoming same-cycle producer data is NOT bypassed.
  - The head entry being written this cycle is still bypassed, so the GPR write-then-read timing is irrelevant.
- idle = (count==0).
- Overflow is prevented by the ready rules. The bench asserts count never exceeds DEPTH.

Decomposition:
- Shared package gpr_pkg: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, NUM_REGS=32.
  - This package is also to be adopted by gpr.
- One natural sub-module: wb_fifo, a DEPTH-entry queue with two push ports and one pop port.
  - It exposes the entry array (rd, data, valid) for bypass search.
- Bypass priority search stays in gpr_writeback.

Test Plan:
- Single ALU write: alu rd=5, data=32'hDEADBEEF, queue empty → gpr_we=1, waddr=5, wdata=DEADBEEF one cycle later; idle returns to 1 the following cycle.
- Dual push ordering: same cycle mem rd=3/data=0x11 and alu rd=3/data=0x22 → GPR writes 0x11 then 0x22 on consecutive cycles. rs_addr=3 reads 0x22 while both are queued, and 0x22 after drain with rs_gpr=0x22.
- Zero register: alu rd=0, data=0xFFFF_FFFF → alu_ready=1, gpr_we stays 0, count stays 0; rs_addr=0 → rs_data=0 even with rs_gpr=0x1234.
- Backpressure, DEPTH=4: hold alu_valid with 4 queued entries → alu_ready=0.
  - With count=3 and both valid, rd≠0: mem_ready=1, alu_ready=0.
  - No entry is lost; the total number of GPR writes equals the number of accepted non-zero-rd results.
- Bypass youngest: queue rd=7 values 0xA, 0xB, 0xC → rt_addr=7 gives 0xC. After two pops it still gives 0xC. After all pops it gives rt_gpr.
- Reset mid-drain: 3 entries queued, assert rst for 1 cycle → gpr_we=0 immediately, idle=1, no further GPR writes after release.

Source files
------------

// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : gpr_pkg
//  Description : Shared GPR widths, zero-register constant and the pending
//                write entry type. Used by the writeback path and by gpr.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // r0 is hard-wired to zero, so writes aimed at it are dropped.
  function automatic logic is_live_rd(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_writeback_if.sv
`default_nettype none
// ============================================================================
//  Interface   : gpr_writeback_if
//  Description : Producer handshakes, GPR write port and decode-stage read
//                bypass signals of the writeback block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpr_writeback_if;
  import gpr_pkg::*;

  // ALU producer
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;
  // Load producer
  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_ready;
  // GPR write port
  logic                  gpr_we;
  logic [REG_ADDR_W-1:0] gpr_waddr;
  logic [DATA_W-1:0]     gpr_wdata;
  // Decode read ports and bypass results
  logic [REG_ADDR_W-1:0] rs_addr;
  logic [REG_ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0]     rs_gpr;
  logic [DATA_W-1:0]     rt_gpr;
  logic [DATA_W-1:0]     rs_data;
  logic [DATA_W-1:0]     rt_data;
  // Status
  logic                  idle;

  // Writeback block side
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  rs_addr, rt_addr, rs_gpr, rt_gpr,
    output alu_ready, mem_ready, gpr_we, gpr_waddr, gpr_wdata,
    output rs_data, rt_data, idle
  );

  // Producers / register file / decode side
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output rs_addr, rt_addr, rs_gpr, rt_gpr,
    input  alu_ready, mem_ready, gpr_we, gpr_waddr, gpr_wdata,
    input  rs_data, rt_data, idle
  );

endinterface
`default_nettype wire

// File: rtl/gpr_writeback_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : DEPTH-entry pending-write queue. Two push ports per cycle
//                (port A is older than port B) and one pop port. The whole
//                entry array is exposed so the owner can search it.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_a,
  input  wire wb_entry_t        push_a_ent,
  input  wire logic             push_b,
  input  wire wb_entry_t        push_b_ent,
  input  wire logic             pop,
  output      wb_entry_t        head,
  output      logic [PTR_W:0]   count,
  output      logic [PTR_W-1:0] rd_ptr,
  output      wb_entry_t        ent [DEPTH],
  output      logic [DEPTH-1:0] ent_valid
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  wb_entry_t        r_ent [DEPTH];

  // Port B lands just behind port A when both push in the same cycle.
  logic [PTR_W-1:0] w_slot_b;
  assign w_slot_b = r_wr_ptr + PTR_W'(push_a);

  // Pointer, occupancy and valid-bit bookkeeping; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (push_a) r_valid[r_wr_ptr] <= 1'b1;
      if (push_b) r_valid[w_slot_b] <= 1'b1;
      r_wr_ptr <= r_wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
      r_count  <= r_count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  // Entry payload storage; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (push_a) r_ent[r_wr_ptr] <= push_a_ent;
    if (push_b) r_ent[w_slot_b] <= push_b_ent;
  end

  assign head      = r_ent[r_rd_ptr];
  assign count     = r_count;
  assign rd_ptr    = r_rd_ptr;
  assign ent       = r_ent;
  assign ent_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/gpr_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_writeback
//  Description : GPR writeback initiator. Queues ALU and load results in
//                program order, drains one per cycle into the GPR write port
//                and bypasses pending writes onto the rs/rt read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_writeback
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input wire logic        clk,
  input wire logic        rst,
  gpr_writeback_if.slave  wb
);

  localparam int               CNT_W        = PTR_W + 1;
  localparam logic [CNT_W-1:0] LVL_ONE_FREE = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LVL_TWO_FREE = CNT_W'(DEPTH - 2);

  wb_entry_t        w_head;
  logic [CNT_W-1:0] w_count;
  logic [PTR_W-1:0] w_rd_ptr;
  wb_entry_t        w_ent [DEPTH];
  logic [DEPTH-1:0] w_valid;

  logic w_mem_ready;
  logic w_mem_take;
  logic w_alu_ready;
  logic w_alu_take;
  logic w_pop;

  // Ready is granted on current occupancy only; a same-cycle pop earns no
  // credit. The load result is older, so it claims a free slot first.
  always_comb begin
    w_mem_ready = !rst && (w_count <= LVL_ONE_FREE);
    w_mem_take  = wb.mem_valid && w_mem_ready && is_live_rd(wb.mem_rd);
    w_alu_ready = !rst && (w_mem_take ? (w_count <= LVL_TWO_FREE)
                                      : (w_count <= LVL_ONE_FREE));
    w_alu_take  = wb.alu_valid && w_alu_ready && is_live_rd(wb.alu_rd);
    w_pop       = !rst && (w_count != '0);
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (w_mem_take),
    .push_a_ent ('{rd: wb.mem_rd, data: wb.mem_data}),
    .push_b     (w_alu_take),
    .push_b_ent ('{rd: wb.alu_rd, data: wb.alu_data}),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_count),
    .rd_ptr     (w_rd_ptr),
    .ent        (w_ent),
    .ent_valid  (w_valid)
  );

  assign wb.mem_ready = w_mem_ready;
  assign wb.alu_ready = w_alu_ready;
  assign wb.gpr_we    = w_pop;
  assign wb.gpr_waddr = w_head.rd;
  assign wb.gpr_wdata = w_head.data;
  assign wb.idle      = (w_count == '0);

  // One bypass search per read port: 0 for r0, else youngest queued match
  // (the head being written this cycle included), else the raw GPR value.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     gpr;
    logic [DATA_W-1:0]     byp;

    assign addr = (p == 0) ? wb.rs_addr : wb.rt_addr;
    assign gpr  = (p == 0) ? wb.rs_gpr  : wb.rt_gpr;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
      logic [PTR_W-1:0] idx;
      byp = gpr;
      idx = w_rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
        idx = w_rd_ptr + PTR_W'(k);
        if (w_valid[idx] && (w_ent[idx].rd == addr)) byp = w_ent[idx].data;
      end
      if (addr == REG_ZERO) byp = '0;
    end
  end

  assign wb.rs_data = g_port[0].byp;
  assign wb.rt_data = g_port[1].byp;

endmodule
`default_nettype wire

// File: tb/tb_gpr_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_writeback
//  Description : Scoreboard bench for gpr_writeback. Directed scenarios plus
//                random producer traffic against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_writeback;
  import gpr_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpr_writeback_if bus ();

  gpr_writeback #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t pend[$];   // architectural pending writes, head popped at the write edge
  wr_t exp_q[$];  // scoreboard of writes the GPR must still see, in order

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register view from decode: r0 is zero, youngest pending write wins.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic [31:0] g);
    if (a == 5'd0) return 32'd0;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].rd == a) return pend[i].data;
    return g;
  endfunction

  // Monitor: every cycle the GPR port must present exactly the next expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      chk("gpr_we", 32'(bus.gpr_we), 32'(exp_q.size() != 0));
      chk("idle", 32'(bus.idle), 32'(exp_q.size() == 0));
      chk("count_bound", 32'(dut.u_fifo.count <= 3'(DEPTH)), 32'd1);
      if (bus.gpr_we && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("gpr_waddr", 32'(bus.gpr_waddr), 32'(e.rd));
        chk("gpr_wdata", bus.gpr_wdata, e.data);
      end
    end
  end

  // One cycle of stimulus: drive, check ready/bypass, then advance the model.
  task automatic step(input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                      input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic [4:0] rsa, input logic [4:0] rta,
                      input logic [31:0] rsg, input logic [31:0] rtg,
                      output bit mt, output bit at);
    bit emr, ear, mtk;
    int n;
    @(negedge clk);
    bus.mem_valid = mv;  bus.mem_rd = mrd;  bus.mem_data = md;
    bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_data = ad;
    bus.rs_addr = rsa;   bus.rt_addr = rta; bus.rs_gpr = rsg; bus.rt_gpr = rtg;
    #1;
    n   = pend.size();
    emr = (n <= DEPTH - 1);
    mtk = mv && emr && (mrd != 5'd0);
    ear = mtk ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
    chk("mem_ready", 32'(bus.mem_ready), 32'(emr));
    chk("alu_ready", 32'(bus.alu_ready), 32'(ear));
    chk("rs_data", bus.rs_data, model_read(rsa, rsg));
    chk("rt_data", bus.rt_data, model_read(rta, rtg));
    mt = mv && emr;
    at = av && ear;
    @(posedge clk);
    if (pend.size() != 0) void'(pend.pop_front());
    if (mt && mrd != 5'd0) begin
      pend.push_back('{mrd, md});
      exp_q.push_back('{mrd, md});
    end
    if (at && ard != 5'd0) begin
      pend.push_back('{ard, ad});
      exp_q.push_back('{ard, ad});
    end
  endtask

  task automatic idle_step(input logic [4:0] rsa, input logic [31:0] rsg,
                           input logic [4:0] rta, input logic [31:0] rtg);
    bit mt, at;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, rsa, rta, rsg, rtg, mt, at);
  endtask

  // Async reset pulse in the middle of a cycle; everything pending is dropped.
  task automatic do_reset();
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.alu_valid = 1'b1;
    #1;
    rst = 1'b1;
    pend.delete();
    exp_q.delete();
    #1;
    chk("rst_gpr_we", 32'(bus.gpr_we), 32'd0);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random producers that hold rd/data until their offer is accepted.
  task automatic run_random(input int cycles, input int pct);
    bit mv = 0, av = 0, mt, at;
    logic [4:0]  mrd = 5'd0, ard = 5'd0;
    logic [31:0] md = 32'd0, ad = 32'd0;
    for (int c = 0; c < cycles; c++) begin
      if (!mv) begin
        mv = ($urandom_range(99) < pct);
        mrd = 5'($urandom_range(7));
        md = $urandom;
      end
      if (!av) begin
        av = ($urandom_range(99) < pct);
        ard = 5'($urandom_range(7));
        ad = $urandom;
      end
      step(mv, mrd, md, av, ard, ad, 5'($urandom_range(7)), 5'($urandom_range(7)),
           $urandom, $urandom, mt, at);
      if (mt) mv = 0;
      if (at) av = 0;
    end
  endtask

  initial begin
    bit mt, at;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd1; bus.mem_data = 32'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'd0;
    bus.rs_addr = 5'd0; bus.rt_addr = 5'd0; bus.rs_gpr = 32'd0; bus.rt_gpr = 32'd0;

    // Reset state with producers offering
    @(negedge clk);
    #1;
    chk("init_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("init_alu_ready", 32'(bus.alu_ready), 32'd0);
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Single ALU write
    step(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'd0, 32'd0, mt, at);
    chk("single_accept", 32'(at), 32'd1);
    repeat (3) idle_step(5'd5, 32'h0, 5'd0, 32'h0);

    // Dual push to the same register: load first, then ALU
    step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 5'd3, 5'd3, 32'h0, 32'h0, mt, at);
    chk("dual_accept", 32'({mt, at}), 32'd3);
    idle_step(5'd3, 32'h55, 5'd3, 32'h66);
    idle_step(5'd3, 32'h55, 5'd3, 32'h66);
    idle_step(5'd3, 32'h22, 5'd3, 32'h22);

    // Zero register: accepted, never written, always reads zero
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 32'h1234, 32'h1234, mt, at);
    chk("zero_accept", 32'(at), 32'd1);
    idle_step(5'd0, 32'h1234, 5'd0, 32'h1234);

    // Bypass youngest of three writes to r7
    step(1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 5'd7, 5'd7, 32'h99, 32'h99, mt, at);
    step(0, 5'd0, 32'd0, 1, 5'd7, 32'hC, 5'd7, 5'd7, 32'h99, 32'h99, mt, at);
    repeat (4) idle_step(5'd7, 32'h99, 5'd7, 32'h99);

    // Backpressure: both producers saturating the queue
    run_random(40, 100);
    repeat (6) idle_step(5'd0, 32'h0, 5'd0, 32'h0);

    // Reset mid-drain with three entries queued
    step(1, 5'd9, 32'h1, 1, 5'd10, 32'h2, 5'd0, 5'd0, 32'h0, 32'h0, mt, at);
    step(1, 5'd11, 32'h3, 1, 5'd12, 32'h4, 5'd0, 5'd0, 32'h0, 32'h0, mt, at);
    chk("pre_reset_depth", 32'(pend.size()), 32'd3);
    do_reset();
    repeat (4) idle_step(5'd10, 32'h77, 5'd11, 32'h88);

    // Random traffic at mixed load
    run_random(300, 60);
    run_random(300, 90);

    // Drain and confirm every accepted write reached the GPR
    for (int i = 0; i < 20 && pend.size() != 0; i++) idle_step(5'd0, 32'h0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
